// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   IFU_ADSIZE / IFU_DASIZE / IFU_FIFO_DEPTH : default widths and prefetch depth
//   ifu_state_e                              : fetch FSM states
//   fetch_entry_t                            : one prefetched word {pc, inst}
package ifu_pkg;

    localparam int IFU_ADSIZE     = 16;
    localparam int IFU_DASIZE     = 32;
    localparam int IFU_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_ADSIZE-1:0] pc;
        logic [IFU_DASIZE-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous prefetch FIFO holding fetched {pc, inst} entries.
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   push, push_data   write one entry (caller guarantees space)
//   pop               remove head; ignored while empty
//   flush             empty the FIFO; takes priority over push and pop
//   head, head_valid  current head entry and its valid flag
//   count             number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH   = IFU_FIFO_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;

    assign do_pop     = pop && (cnt != '0);
    assign head       = mem[rd_ptr];
    assign head_valid = (cnt != '0);
    assign count      = cnt;

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Credit accounting upstream must never let a push land on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !flush && !do_pop && (cnt == FULL)));

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit, initiator side of the instruction memory port.
// Issues word reads from pc, captures IM_out one cycle later into a prefetch FIFO and
// presents {inst_pc, inst_data} to decode over a valid/ready handshake.
// Ports:
//   clk, rst                       clock and asynchronous active-low reset
//   fetch_en                       allow new reads
//   boot_pc                        start PC loaded when leaving IDLE
//   redirect_valid, redirect_pc    one-cycle redirect request and target
//   IM_enable, IM_write,
//   IM_address, IM_in, IM_out      instruction memory port (read-only use)
//   inst_valid, inst_ready,
//   inst_data, inst_pc             decode handshake (FIFO head)
//   perf_fetch_cnt, perf_stall_cnt only when IFU_PERF_CNT_EN is defined
// Optional feature macro: IFU_PERF_CNT_EN adds saturating counters of pushed words and
// of FETCH cycles blocked by lack of FIFO credit.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int ADSize     = IFU_ADSIZE,
    parameter int DASize     = IFU_DASIZE,
    parameter int FIFO_DEPTH = IFU_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADSize-1:0] boot_pc,
    input  logic              redirect_valid,
    input  logic [ADSize-1:0] redirect_pc,
    output logic              IM_enable,
    output logic              IM_write,
    output logic [ADSize-1:0] IM_address,
    output logic [DASize-1:0] IM_in,
    input  logic [DASize-1:0] IM_out,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DASize-1:0] inst_data,
    output logic [ADSize-1:0] inst_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADSize-1:0] pc;
        logic [DASize-1:0] inst;
    } entry_t;

    ifu_state_e        state;
    logic [ADSize-1:0] pc;
    logic [ADSize-1:0] req_pc;
    logic              pending;
    logic              kill;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       in_use;
    entry_t            push_entry;
    entry_t            head;

    // A read in flight already owns a FIFO slot, so credit counts it with the
    // stored entries; this is what makes overflow impossible.
    assign in_use    = {1'b0, fifo_count} + {{CW{1'b0}}, pending};
    assign credit_ok = (in_use < (CW+1)'(FIFO_DEPTH));

    // A redirect discards the word returning this cycle and blocks issue.
    assign kill  = redirect_valid;
    assign issue = (state == FETCH) && fetch_en && credit_ok && !kill;
    assign push  = pending && !kill;

    assign IM_enable  = issue;
    assign IM_address = pc;
    assign IM_write   = 1'b0;
    assign IM_in      = '0;

    assign push_entry = '{pc: req_pc, inst: IM_out};

    ifu_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_entry),
        .pop        (inst_ready),
        .flush      (redirect_valid),
        .head       (head),
        .head_valid (inst_valid),
        .count      (fifo_count)
    );

    assign inst_data = head.inst;
    assign inst_pc   = head.pc;

    // FSM plus PC/pending tracking. Redirect has priority over the boot load and
    // the post-issue increment; pc wraps naturally at the address width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= '0;
            req_pc  <= '0;
            pending <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                req_pc <= pc;
            end

            case (state)
                IDLE:    if (fetch_en) state <= FETCH;
                FETCH:   if (!fetch_en) state <= DRAIN;
                DRAIN:   if (!pending) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if ((state == IDLE) && fetch_en) begin
                pc <= boot_pc;
            end else if (issue) begin
                pc <= pc + 1'b1;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic stall;

    assign stall = (state == FETCH) && fetch_en && !redirect_valid && !credit_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch with a scoreboard of expected
// {pc, inst} deliveries and directed scenarios (stream, stall, redirect, wrap, reset).
module tb_ifu_fetch;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic [15:0] boot_pc = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        IM_enable;
    logic        IM_write;
    logic [15:0] IM_address;
    logic [31:0] IM_in;
    logic [31:0] IM_out = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [15:0] inst_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int          compared = 0;
    int          mismatched = 0;
    int          write_violations = 0;
    logic [31:0] mem_xor = '0;
    exp_t        exp_q[$];

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .boot_pc        (boot_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .IM_enable      (IM_enable),
        .IM_write       (IM_write),
        .IM_address     (IM_address),
        .IM_in          (IM_in),
        .IM_out         (IM_out),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: word n holds n, optionally XOR-ed with a scenario tag.
    function automatic logic [31:0] memWord(input logic [15:0] a);
        return {16'h0000, a} ^ mem_xor;
    endfunction

    // Memory model: data for an enabled read appears the following cycle.
    always @(posedge clk) begin
        if (IM_enable) IM_out <= memWord(IM_address);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic fe, input logic [15:0] boot,
                                 input logic rv, input logic [15:0] rpc, input logic rdy);
        fetch_en       = fe;
        boot_pc        = boot;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic expectRange(input logic [15:0] start, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 16'(i);
            exp_q.push_back('{pc: a, inst: memWord(a)});
        end
    endtask

    task automatic applyReset();
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        exp_q.delete();
        nextEdge();
        nextEdge();
        checkOutput("rst_im_enable", 64'(IM_enable), 64'd0);
        checkOutput("rst_im_address", 64'(IM_address), 64'd0);
        checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("rst_inst_data", 64'(inst_data), 64'd0);
        checkOutput("rst_inst_pc", 64'(inst_pc), 64'd0);
`ifdef IFU_PERF_CNT_EN
        checkOutput("rst_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
        checkOutput("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
        rst = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            nextEdge();
            n++;
        end
        checkOutput({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (3) nextEdge();
        checkOutput({name, "_empty_after"}, 64'(inst_valid), 64'd0);
    endtask

    // Scoreboard monitor: every accepted handshake must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_delivery: got pc 0x%0h inst 0x%0h, expected none",
                         inst_pc, inst_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("deliver_pc", 64'(inst_pc), 64'(e.pc));
                checkOutput("deliver_inst", 64'(inst_data), 64'(e.inst));
            end
        end
    end

    always @(negedge clk) begin
        if (IM_write !== 1'b0 || IM_in !== 32'h0) write_violations++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int en_cnt;
        logic [15:0] wrap_addr [4];
        wrap_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        // Streaming fetch from 0x0010 with decode always ready.
        $display("[TB] scenario 1: stream");
        mem_xor = 32'h0;
        applyReset();
        expectRange(16'h0010, 8);
        applyStimulus(1'b1, 16'h0010, 1'b0, 16'h0, 1'b1);
        midCycle();
        checkOutput("s1_idle_no_issue", 64'(IM_enable), 64'd0);
        nextEdge();
        midCycle();
        checkOutput("s1_first_enable", 64'(IM_enable), 64'd1);
        checkOutput("s1_first_addr", 64'(IM_address), 64'h10);
        checkOutput("s1_valid_lat1", 64'(inst_valid), 64'd0);
        nextEdge();
        midCycle();
        checkOutput("s1_second_addr", 64'(IM_address), 64'h11);
        checkOutput("s1_valid_lat2", 64'(inst_valid), 64'd0);
        nextEdge();
        midCycle();
        checkOutput("s1_valid_after2", 64'(inst_valid), 64'd1);
        checkOutput("s1_third_addr", 64'(IM_address), 64'h12);
        repeat (6) nextEdge();
        applyStimulus(1'b0, 16'h0010, 1'b0, 16'h0, 1'b1);
        en_cnt = 0;
        repeat (6) begin
            midCycle();
            en_cnt += int'(IM_enable);
        end
        checkOutput("s1_enable_after_stop", 64'(en_cnt), 64'd0);
        waitDrain("s1");

        // Decode stalled: exactly four reads fill the FIFO, then resume.
        $display("[TB] scenario 2: stall");
        mem_xor = 32'hC0DE_0000;
        applyReset();
        expectRange(16'h0040, 7);
        applyStimulus(1'b1, 16'h0040, 1'b0, 16'h0, 1'b0);
        en_cnt = 0;
        repeat (8) begin
            nextEdge();
            midCycle();
            en_cnt += int'(IM_enable);
        end
        checkOutput("s2_issues_while_stalled", 64'(en_cnt), 64'd4);
        checkOutput("s2_held_valid", 64'(inst_valid), 64'd1);
        checkOutput("s2_held_pc", 64'(inst_pc), 64'h40);
        checkOutput("s2_held_data", 64'(inst_data), 64'hC0DE_0040);
        nextEdge();
        applyStimulus(1'b1, 16'h0040, 1'b0, 16'h0, 1'b1);
        repeat (4) nextEdge();
        applyStimulus(1'b0, 16'h0040, 1'b0, 16'h0, 1'b1);
        waitDrain("s2");
`ifdef IFU_PERF_CNT_EN
        checkOutput("s2_perf_fetch", 64'(perf_fetch_cnt), 64'd7);
        checkOutput("s2_perf_stall", 64'(perf_stall_cnt), 64'd5);
`endif

        // Redirect while a read is in flight and the FIFO holds a word.
        $display("[TB] scenario 3: redirect");
        applyReset();
        expectRange(16'h0200, 3);
        applyStimulus(1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
        nextEdge();
        nextEdge();
        nextEdge();
        applyStimulus(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
        midCycle();
        checkOutput("s3_no_issue_on_redirect", 64'(IM_enable), 64'd0);
        nextEdge();
        applyStimulus(1'b1, 16'h0100, 1'b0, 16'h0, 1'b1);
        midCycle();
        checkOutput("s3_flushed", 64'(inst_valid), 64'd0);
        checkOutput("s3_target_enable", 64'(IM_enable), 64'd1);
        checkOutput("s3_target_addr", 64'(IM_address), 64'h200);
        repeat (3) nextEdge();
        applyStimulus(1'b0, 16'h0100, 1'b0, 16'h0, 1'b1);
        waitDrain("s3");

        // PC wrap across the top of the address space.
        $display("[TB] scenario 4: wrap");
        applyReset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{pc: wrap_addr[i], inst: memWord(wrap_addr[i])});
        end
        applyStimulus(1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            nextEdge();
            midCycle();
            checkOutput("s4_wrap_addr", 64'(IM_address), 64'(wrap_addr[i]));
        end
        nextEdge();
        applyStimulus(1'b0, 16'hFFFE, 1'b0, 16'h0, 1'b1);
        waitDrain("s4");

        // Asynchronous reset in the middle of a stream.
        $display("[TB] scenario 5: async reset");
        applyReset();
        applyStimulus(1'b1, 16'h0300, 1'b0, 16'h0, 1'b0);
        repeat (4) nextEdge();
        midCycle();
        checkOutput("s5_pre_valid", 64'(inst_valid), 64'd1);
        checkOutput("s5_pre_enable", 64'(IM_enable), 64'd1);
        #2;
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        #1;
        checkOutput("s5_async_enable", 64'(IM_enable), 64'd0);
        checkOutput("s5_async_addr", 64'(IM_address), 64'd0);
        checkOutput("s5_async_valid", 64'(inst_valid), 64'd0);
        checkOutput("s5_async_data", 64'(inst_data), 64'd0);
        checkOutput("s5_async_pc", 64'(inst_pc), 64'd0);
        nextEdge();
        nextEdge();
        rst = 1'b1;
        repeat (3) nextEdge();
        midCycle();
        checkOutput("s5_inflight_dropped", 64'(inst_valid), 64'd0);
        checkOutput("s5_idle_enable", 64'(IM_enable), 64'd0);

        checkOutput("im_write_in_const_zero", 64'(write_violations), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
